// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: ROM geometry and the
// owner encoding used to tag the single in-flight read.
package rom_arbiter_pkg;

    localparam int ROM_ADDRESS_BITWIDTH = 16;
    localparam int ROM_SIZE             = 1 << (ROM_ADDRESS_BITWIDTH - 2);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LD = 1'b1
    } owner_e;

endpackage

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between instruction
// fetch (IF) and constant loads (LD), with valid/ready responses and IF flush.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [31:0]       if_rsp_data,
    input  logic              if_flush,

    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [31:0]       ld_rsp_data,

    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_data
);

    logic              pend_valid_q, pend_valid_d;
    owner_e            pend_owner_q, pend_owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] last_addr_q,  last_addr_d;

    logic   if_pend;
    logic   slot_free;
    logic   if_elig;
    logic   ld_elig;
    logic   grant;
    owner_e grantee;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pend_valid_d = pend_valid_q;
        pend_owner_d = pend_owner_q;
        last_grant_d = last_grant_q;
        grantee      = OWNER_IF;

        if_pend      = pend_valid_q && (pend_owner_q == OWNER_IF);
        if_rsp_valid = reset_n && if_pend && !if_flush;
        ld_rsp_valid = reset_n && pend_valid_q && (pend_owner_q == OWNER_LD);
        if_rsp_data  = rom_data;
        ld_rsp_data  = rom_data;

        // The slot frees on a response handshake or when a pending fetch is flushed.
        slot_free = !pend_valid_q
                  || (if_rsp_valid && if_rsp_ready)
                  || (ld_rsp_valid && ld_rsp_ready)
                  || (if_pend && if_flush);

        if_elig = reset_n && if_req_valid && !if_flush;
        ld_elig = reset_n && ld_req_valid;
        grant   = slot_free && (if_elig || ld_elig);

        if (if_elig && ld_elig) begin
            grantee = (last_grant_q == OWNER_IF) ? OWNER_LD : OWNER_IF;
        end else if (ld_elig) begin
            grantee = OWNER_LD;
        end

        if_req_ready = grant && (grantee == OWNER_IF);
        ld_req_ready = grant && (grantee == OWNER_LD);

        // Holding the previous address keeps rom_data stable across a stall.
        if (!reset_n) begin
            rom_address = '0;
        end else if (grant) begin
            rom_address = (grantee == OWNER_IF) ? if_req_addr : ld_req_addr;
        end else begin
            rom_address = last_addr_q;
        end

        if (grant) begin
            pend_valid_d = 1'b1;
            pend_owner_d = grantee;
            last_grant_d = grantee;
        end else if (slot_free) begin
            pend_valid_d = 1'b0;
        end
        last_addr_d = rom_address;
    end

    // NOTE: state flops use non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_owner_q <= OWNER_IF;
            last_grant_q <= OWNER_LD;
            last_addr_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
            last_grant_q <= last_grant_d;
            last_addr_q  <= last_addr_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: a transaction-level model (one-deep
// request queue plus round-robin pointer) checked every cycle, plus directed cases.
module tb_rom_arbiter;

    localparam int AW   = 16;
    localparam bit M_IF = 1'b0;
    localparam bit M_LD = 1'b1;

    logic          clk;
    logic          reset_n;
    logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_flush;
    logic [AW-1:0] if_req_addr;
    logic [31:0]   if_rsp_data;
    logic          ld_req_valid, ld_req_ready, ld_rsp_valid, ld_rsp_ready;
    logic [AW-1:0] ld_req_addr;
    logic [31:0]   ld_rsp_data;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_data;

    int checks   = 0;
    int failures = 0;

    rom_arbiter #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_flush     (if_flush),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_addr  (ld_req_addr),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_data  (ld_rsp_data),
        .rom_address  (rom_address),
        .rom_data     (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: 256 words, address registered each posedge.
    logic [31:0]   rom_mem [256];
    logic [AW-1:0] rom_addr_q;
    always @(posedge clk) rom_addr_q <= rom_address;
    assign rom_data = rom_mem[rom_addr_q[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue holding at most one outstanding read.
    typedef struct {
        bit            owner;
        logic [AW-1:0] addr;
    } req_t;

    req_t          pend_q[$];
    req_t          m_head;
    bit            m_last_grant;
    logic [AW-1:0] m_last_addr;
    bit            m_pend, m_done, want_if, want_ld;
    bit            e_if_rv, e_ld_rv, e_grant_if, e_grant_ld;
    logic [AW-1:0] e_addr;

    initial begin
        m_head       = '{owner: M_IF, addr: '0};
        m_last_grant = M_LD;
        m_last_addr  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_rom_address", 32'(rom_address), 32'h0);
                check("rst_if_rsp_valid", 32'(if_rsp_valid), 32'h0);
                check("rst_ld_rsp_valid", 32'(ld_rsp_valid), 32'h0);
                check("rst_if_req_ready", 32'(if_req_ready), 32'h0);
                check("rst_ld_req_ready", 32'(ld_req_ready), 32'h0);
                pend_q.delete();
                m_last_grant = M_LD;
                m_last_addr  = '0;
            end else begin
                m_pend = (pend_q.size() != 0);
                if (m_pend) m_head = pend_q[0];
                e_if_rv = m_pend && (m_head.owner == M_IF) && !if_flush;
                e_ld_rv = m_pend && (m_head.owner == M_LD);
                m_done  = !m_pend || (e_if_rv && if_rsp_ready) || (e_ld_rv && ld_rsp_ready)
                        || (m_pend && (m_head.owner == M_IF) && if_flush);
                want_if = if_req_valid && !if_flush;
                want_ld = ld_req_valid;
                e_grant_if = 1'b0;
                e_grant_ld = 1'b0;
                if (m_done) begin
                    if (want_if && want_ld) begin
                        if (m_last_grant == M_IF) e_grant_ld = 1'b1;
                        else                      e_grant_if = 1'b1;
                    end else begin
                        e_grant_if = want_if;
                        e_grant_ld = want_ld;
                    end
                end
                e_addr = e_grant_if ? if_req_addr : (e_grant_ld ? ld_req_addr : m_last_addr);

                check("m_if_req_ready", 32'(if_req_ready), 32'(e_grant_if));
                check("m_ld_req_ready", 32'(ld_req_ready), 32'(e_grant_ld));
                check("m_rom_address", 32'(rom_address), 32'(e_addr));
                check("m_if_rsp_valid", 32'(if_rsp_valid), 32'(e_if_rv));
                check("m_ld_rsp_valid", 32'(ld_rsp_valid), 32'(e_ld_rv));
                if (e_if_rv && if_rsp_valid)
                    check("m_if_rsp_data", if_rsp_data, rom_mem[m_head.addr[9:2]]);
                if (e_ld_rv && ld_rsp_valid)
                    check("m_ld_rsp_data", ld_rsp_data, rom_mem[m_head.addr[9:2]]);

                if (m_pend && m_done) void'(pend_q.pop_front());
                if (e_grant_if) begin
                    pend_q.push_back('{owner: M_IF, addr: if_req_addr});
                    m_last_grant = M_IF;
                end else if (e_grant_ld) begin
                    pend_q.push_back('{owner: M_LD, addr: ld_req_addr});
                    m_last_grant = M_LD;
                end
                m_last_addr = e_addr;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rom_mem[2]  = 32'h00A00513;
        rom_mem[4]  = 32'hCAFE0004;
        rom_mem[8]  = 32'hBEEF0008;
        rom_mem[9]  = 32'h55550009;
        rom_mem[12] = 32'h1234000C;
        rom_mem[17] = 32'h77770011;
        rom_mem[20] = 32'h99990014;

        // Reset with requests asserted: they must be gated off.
        reset_n      = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0044;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0048;
        if_rsp_ready = 1'b1;
        ld_rsp_ready = 1'b1;
        if_flush     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rom_address", 32'(rom_address), 32'h0);
        check("reset_if_ready", 32'(if_req_ready), 32'h0);
        check("reset_ld_ready", 32'(ld_req_ready), 32'h0);
        check("reset_if_rsp_valid", 32'(if_rsp_valid), 32'h0);

        // Single fetch.
        step();
        reset_n      = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0008;
        ld_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_if_ready", 32'(if_req_ready), 32'h1);
        check("fetch_rom_address", 32'(rom_address), 32'h8);
        step();
        if_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_rsp_valid", 32'(if_rsp_valid), 32'h1);
        check("fetch_rsp_data", if_rsp_data, 32'h00A00513);
        check("fetch_ld_rsp_valid", 32'(ld_rsp_valid), 32'h0);

        // Contention from a fresh reset: IF, LD, IF, LD.
        step();
        reset_n = 1'b0;
        step();
        reset_n      = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0010;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_if_ready", 32'(if_req_ready), 32'((k % 2) == 0));
            check("cont_ld_ready", 32'(ld_req_ready), 32'((k % 2) == 1));
            if (k % 2 == 1) begin
                check("cont_if_rsp_valid", 32'(if_rsp_valid), 32'h1);
                check("cont_if_rsp_data", if_rsp_data, 32'hCAFE0004);
            end else if (k > 0) begin
                check("cont_ld_rsp_valid", 32'(ld_rsp_valid), 32'h1);
                check("cont_ld_rsp_data", ld_rsp_data, 32'hBEEF0008);
            end
            step();
        end
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        @(negedge clk);
        check("cont_last_ld_rsp_valid", 32'(ld_rsp_valid), 32'h1);
        check("cont_last_ld_rsp_data", ld_rsp_data, 32'hBEEF0008);
        step();

        // Back-pressure on a pending IF response.
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0030;
        if_rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_if_ready", 32'(if_req_ready), 32'h1);
        step();
        if_req_valid = 1'b0;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0024;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_if_rsp_valid", 32'(if_rsp_valid), 32'h1);
            check("bp_if_rsp_data", if_rsp_data, 32'h1234000C);
            check("bp_rom_address", 32'(rom_address), 32'h30);
            check("bp_ld_ready", 32'(ld_req_ready), 32'h0);
            step();
        end
        if_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ld_ready", 32'(ld_req_ready), 32'h1);
        check("bp_release_rom_address", 32'(rom_address), 32'h24);
        step();
        ld_req_valid = 1'b0;
        @(negedge clk);
        check("bp_ld_rsp_data", ld_rsp_data, 32'h55550009);
        step();

        // Flush of a pending IF response frees the slot for LD.
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0040;
        @(negedge clk);
        check("flush_if_ready", 32'(if_req_ready), 32'h1);
        step();
        if_req_addr  = 16'h0048;
        if_flush     = 1'b1;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0044;
        @(negedge clk);
        check("flush_if_rsp_valid", 32'(if_rsp_valid), 32'h0);
        check("flush_ld_ready", 32'(ld_req_ready), 32'h1);
        check("flush_if_ready", 32'(if_req_ready), 32'h0);
        step();
        if_flush     = 1'b0;
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        @(negedge clk);
        check("flush_dropped", 32'(if_rsp_valid), 32'h0);
        check("flush_ld_rsp_data", ld_rsp_data, 32'h77770011);
        step();

        // Reset while an LD response is stalled.
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0050;
        ld_rsp_ready = 1'b0;
        @(negedge clk);
        check("rstall_ld_ready", 32'(ld_req_ready), 32'h1);
        step();
        ld_req_valid = 1'b0;
        @(negedge clk);
        check("rstall_ld_rsp_data", ld_rsp_data, 32'h99990014);
        step();
        reset_n = 1'b0;
        @(negedge clk);
        check("rstall_in_reset_ld_rsp_valid", 32'(ld_rsp_valid), 32'h0);
        step();
        reset_n      = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0060;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0064;
        ld_rsp_ready = 1'b1;
        @(negedge clk);
        check("rstall_tie_if", 32'(if_req_ready), 32'h1);
        check("rstall_tie_ld", 32'(ld_req_ready), 32'h0);
        check("rstall_ld_rsp_gone", 32'(ld_rsp_valid), 32'h0);
        step();

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            reset_n      = ($urandom_range(0, 99) != 0);
            if_req_valid = ($urandom_range(0, 3) != 0);
            ld_req_valid = ($urandom_range(0, 2) != 0);
            if_req_addr  = 16'($urandom_range(0, 1023));
            ld_req_addr  = 16'($urandom_range(0, 1023));
            if_rsp_ready = ($urandom_range(0, 3) != 0);
            ld_rsp_ready = ($urandom_range(0, 3) != 0);
            if_flush     = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
